param_ram: RTL and testbench
============================

# param_ram

Parameterised register-file RAM of 2**SEL_WIDTH words, each BIT_WIDTH bits wide, with one synchronous write port and every stored word continuously visible on a parallel output array. It is the general, width- and depth-configurable storage primitive of the sequential layer (the RAM8 case is SEL_WIDTH=3). It sits between the datapath and the register/memory consumers that need all words at once.

## Interface
Parameters:
- BIT_WIDTH, default 4: width of each stored word and of `in`.
- SEL_WIDTH, default 4: address width; depth = 2**SEL_WIDTH words.

Ports:
- clock  input  1  single system clock; all writes on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears every word.
- out  output  BIT_WIDTH x 2**SEL_WIDTH (unpacked array, index 2**SEL_WIDTH-1 : 0)  current contents of every word; `out[k]` is word k.
- in  input  BIT_WIDTH  write data.
- address  input  SEL_WIDTH  write address.
- load  input  1  write enable, active-high.

Port order: out, in, address, load, clock, reset (positional instantiation relies on it).

## Operation
- Storage: 2**SEL_WIDTH independent BIT_WIDTH-bit registers.
- Write: on rising `clock` with `load`=1 and `reset` high, word[`address`] takes `in`; all other words hold.
- `load`=0: no word changes.
- Read: `out[k]` is driven directly from register k; no read address, no read latency beyond the register itself.
- Every address in 0..2**SEL_WIDTH-1 is valid; no out-of-range case exists.
- Rewriting a word overwrites it; other words, including previously written ones, are unaffected.

## Timing
- Reset: `reset` low forces every word, hence every `out[k]`, to 0 immediately (asynchronous), independent of `clock` and `load`. Held low, writes are ignored.
- Reset release: first rising edge after `reset` goes high may write.
- Write latency: `out[address]` shows `in` after the rising edge that samples `load`=1; visible in the same cycle after that edge.
- Reset asserted mid-cycle with `load`=1: reset wins; word stays 0.
- Changes on `in`/`address` between edges have no effect on stored data.

## Configuration
- Macro `PARAM_RAM_RDPORT_EN`:
  - Defined: adds output `rd_data` (BIT_WIDTH, placed after `reset` in port order), combinationally equal to word[`address`]; after a write it reflects the new value following the edge.
  - Undefined: port absent; only `out` array provides read access. Storage behaviour identical in both cases.

## Structure
- Package `param_ram_pkg`: default BIT_WIDTH / SEL_WIDTH constants and a localparam-style helper for depth (2**SEL_WIDTH).
- One sub-module `param_ram_word`: BIT_WIDTH-bit register with `load`, async active-low `reset`, rising-edge `clock`. Top level instantiates 2**SEL_WIDTH copies in a generate loop; per-word load = `load` AND (`address` == k).
- Optional read mux for `rd_data` lives in the top level under the macro.

## Test plan
- Reset: hold `reset` low 1 cycle with `load`=0 -> all 16 `out[k]` = 0; release -> still 0.
- Sequential fill (BIT_WIDTH=4, SEL_WIDTH=4): `load`=1, for i=0..15 drive `address`=i, `in`=i for one cycle -> after each edge `out[i]`=i; at end `out[k]`=k for all k.
- Overwrite: after fill, `address`=0, `in`=5, one cycle -> `out[0]`=5, `out[5]`=5, `out[1]`=1, others unchanged.
- Hold: `load`=0, `address`=3, `in`=15 for 3 cycles -> `out[3]` stays 3, no word changes.
- Async reset mid-operation: after fill, pull `reset` low between edges -> all `out[k]` = 0 before next edge; writes with `load`=1 while low ignored.
- With `PARAM_RAM_RDPORT_EN`: after fill, `address`=9 -> `rd_data`=9; write `in`=2 at address 9 -> `rd_data`=2 after edge.

Source files
------------

// File: rtl/param_ram_pkg.sv
// Shared defaults and the depth helper for the param_ram register-file RAM.
package param_ram_pkg;

    localparam int DEFAULT_BIT_WIDTH = 4;
    localparam int DEFAULT_SEL_WIDTH = 4;

    // Number of words addressed by a sel_width-bit address.
    function automatic int depth(input int sel_width);
        return 1 << sel_width;
    endfunction

endpackage

// File: rtl/param_ram_word.sv
// One BIT_WIDTH-bit storage word: rising-edge write when load is high, async active-low clear.
module param_ram_word #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] data,
    input  logic                 load,
    input  logic                 clock,
    input  logic                 reset,
    output logic [BIT_WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end
    end

endmodule

// File: rtl/param_ram.sv
// Register-file RAM of 2**SEL_WIDTH words with all words exposed on out[].
// Optional macro PARAM_RAM_RDPORT_EN adds a combinational rd_data = word[address].
module param_ram
    import param_ram_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
    output logic [BIT_WIDTH-1:0] out [2**SEL_WIDTH-1:0],
    input  logic [BIT_WIDTH-1:0] in,
    input  logic [SEL_WIDTH-1:0] address,
    input  logic                 load,
    input  logic                 clock,
    input  logic                 reset
`ifdef PARAM_RAM_RDPORT_EN
    ,
    output logic [BIT_WIDTH-1:0] rd_data
`endif
);

    localparam int DEPTH = depth(SEL_WIDTH);

    // Each word sees the shared data bus; only the addressed word gets its load.
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        logic word_load;

        assign word_load = load && (address == SEL_WIDTH'(k));

        param_ram_word #(
            .BIT_WIDTH(BIT_WIDTH)
        ) u_word (
            .data (in),
            .load (word_load),
            .clock(clock),
            .reset(reset),
            .q    (out[k])
        );
    end

`ifdef PARAM_RAM_RDPORT_EN
    assign rd_data = out[address];
`endif

endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram (BIT_WIDTH=4, SEL_WIDTH=4) with a scoreboard queue.
module tb_param_ram;

    localparam int BW    = 4;
    localparam int SW    = 4;
    localparam int DEPTH = 1 << SW;

    logic [BW-1:0] out_w [DEPTH-1:0];
    logic [BW-1:0] in_d;
    logic [SW-1:0] address;
    logic          load;
    logic          clock;
    logic          reset;
`ifdef PARAM_RAM_RDPORT_EN
    logic [BW-1:0] rd_data;
`endif

    logic [BW-1:0] model [DEPTH-1:0];
    logic [BW-1:0] exp_q [$];
    int total;
    int bad;

    param_ram #(
        .BIT_WIDTH(BW),
        .SEL_WIDTH(SW)
    ) dut (
        .out    (out_w),
        .in     (in_d),
        .address(address),
        .load   (load),
        .clock  (clock),
        .reset  (reset)
`ifdef PARAM_RAM_RDPORT_EN
        ,
        .rd_data(rd_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("%s_w%0d", tag, k), out_w[k], model[k]);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
    endtask

    // One write cycle: drive at negedge, expect the word after the next rising edge.
    task automatic write_word(input logic [SW-1:0] a, input logic [BW-1:0] d, input string tag);
        @(negedge clock);
        address = a;
        in_d    = d;
        load    = 1'b1;
        model[a] = d;
        exp_q.push_back(d);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            check(tag, out_w[a], exp_q.pop_front());
        end
    endtask

    task automatic idle_cycle(input logic [SW-1:0] a, input logic [BW-1:0] d);
        @(negedge clock);
        address = a;
        in_d    = d;
        load    = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        load    = 1'b0;
        in_d    = '0;
        address = '0;
        clear_model();

        // Reset held low for a cycle, then released.
        @(posedge clock);
        #1;
        check_all("reset_low");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("reset_release");

        // Sequential fill: word i gets i.
        for (int i = 0; i < DEPTH; i++) begin
            write_word(SW'(i), BW'(i), $sformatf("fill_%0d", i));
        end
        check_all("fill_done");

        // Overwrite word 0; neighbours unaffected.
        write_word(4'd0, 4'd5, "overwrite_0");
        check_all("overwrite_all");

        // load low: nothing may change regardless of address/in.
        for (int c = 0; c < 3; c++) begin
            idle_cycle(4'd3, 4'hf);
            check($sformatf("hold_w3_c%0d", c), out_w[3], model[3]);
        end
        check_all("hold_all");

        // Random writes interleaved with idle cycles.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle(SW'($urandom_range(0, DEPTH - 1)), BW'($urandom_range(0, (1 << BW) - 1)));
            end else begin
                write_word(SW'($urandom_range(0, DEPTH - 1)), BW'($urandom_range(0, (1 << BW) - 1)),
                           $sformatf("rand_%0d", n));
            end
        end
        check_all("rand_all");

`ifdef PARAM_RAM_RDPORT_EN
        write_word(4'd9, 4'd9, "rd_prep");
        @(negedge clock);
        load    = 1'b0;
        address = 4'd9;
        #1;
        check("rd_data_9", rd_data, 4'd9);
        write_word(4'd9, 4'd2, "rd_write");
        check("rd_data_after", rd_data, 4'd2);
`endif

        // Refill so the async clear below has nonzero words to wipe.
        for (int i = 0; i < DEPTH; i++) begin
            write_word(SW'(i), BW'(DEPTH - 1 - i), $sformatf("refill_%0d", i));
        end
        check_all("refill_done");

        // Async reset between edges with load high: clears at once, write ignored.
        @(negedge clock);
        address = 4'd7;
        in_d    = 4'ha;
        load    = 1'b1;
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check_all("async_mid");
        @(posedge clock);
        #1;
        check_all("async_edge");

        // After release the first edge writes again.
        @(negedge clock);
        reset = 1'b1;
        load  = 1'b0;
        write_word(4'd7, 4'ha, "post_reset_write");
        check_all("post_reset_all");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
